// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: sequences the core reset, enforces a run-cycle budget and
// classifies the run (pass / fail signature, stall, timeout) from the core's
// debug bus. A restart pulse re-runs the whole sequence without a global reset.
`timescale 1ns/1ps
module cpu_run_monitor #(
    parameter int unsigned        DBG_W        = 32,
    parameter int unsigned        CNT_W        = 32,
    parameter int unsigned        RST_CYCLES   = 10,
    parameter int unsigned        MAX_CYCLES   = 1000000,
    parameter logic [DBG_W-1:0]   PASS_SIG     = 32'h600DC0DE,
    parameter logic [DBG_W-1:0]   FAIL_SIG     = 32'hBADC0DE0,
    parameter int unsigned        STALL_CYCLES = 0,
    parameter bit                 HALT_ON_DONE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DBG_W-1:0] dbg_out,
    output logic             cpu_rst_n,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             stall,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       state
);

    localparam int unsigned HOLD_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam bit          STALL_EN = (STALL_CYCLES != 0);

    // Parameter sanity: bad configurations must not elaborate.
    if (PASS_SIG == FAIL_SIG) begin : g_err_sig
        $error("cpu_run_monitor: PASS_SIG must differ from FAIL_SIG");
    end
    if (RST_CYCLES == 0) begin : g_err_rst
        $error("cpu_run_monitor: RST_CYCLES must be at least 1");
    end
    if (CNT_W < 64 && ((64'(MAX_CYCLES) >> CNT_W) != 64'd0)) begin : g_err_max
        $error("cpu_run_monitor: MAX_CYCLES does not fit in CNT_W bits");
    end

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_STALL   = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    state_t             r_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [DBG_W-1:0]   r_dbg_q;
    logic               r_cpu_rst_n;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;
    logic               r_timeout;
    logic               r_stall;

    state_t             w_state_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [CNT_W-1:0]   w_cycle_nxt;
    logic [CNT_W-1:0]   w_stall_cnt_nxt;
    logic [DBG_W-1:0]   w_dbg_nxt;
    logic               w_cpu_rst_n_nxt;
    logic               w_done_nxt;
    logic               w_pass_nxt;
    logic               w_fail_nxt;
    logic               w_timeout_nxt;
    logic               w_stall_nxt;
    logic               w_unchanged;
    logic               w_terminal;

    // Next-state and next-output logic; restart overrides every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold_cnt;
        w_cycle_nxt     = r_cycle_cnt;
        w_stall_cnt_nxt = r_stall_cnt;
        w_dbg_nxt       = r_dbg_q;
        w_cpu_rst_n_nxt = r_cpu_rst_n;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_fail_nxt      = r_fail;
        w_timeout_nxt   = r_timeout;
        w_stall_nxt     = r_stall;
        w_terminal      = 1'b0;
        // The first RUN cycle has no meaningful previous sample.
        w_unchanged     = (r_cycle_cnt != {CNT_W{1'b0}}) && (dbg_out == r_dbg_q);

        if (restart) begin
            w_state_nxt     = ST_HOLD;
            w_hold_nxt      = {HOLD_W{1'b0}};
            w_cycle_nxt     = {CNT_W{1'b0}};
            w_stall_cnt_nxt = {CNT_W{1'b0}};
            w_dbg_nxt       = {DBG_W{1'b0}};
            w_cpu_rst_n_nxt = 1'b0;
            w_done_nxt      = 1'b0;
            w_pass_nxt      = 1'b0;
            w_fail_nxt      = 1'b0;
            w_timeout_nxt   = 1'b0;
            w_stall_nxt     = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_cpu_rst_n_nxt = 1'b0;
                    if (r_hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                        w_state_nxt     = ST_RUN;
                        w_cpu_rst_n_nxt = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    w_cycle_nxt = r_cycle_cnt + CNT_W'(1);
                    w_dbg_nxt   = dbg_out;
                    if (STALL_EN && w_unchanged) begin
                        w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
                    end else begin
                        w_stall_cnt_nxt = {CNT_W{1'b0}};
                    end
                    if (dbg_out == FAIL_SIG) begin
                        w_state_nxt = ST_FAIL;
                        w_fail_nxt  = 1'b1;
                        w_terminal  = 1'b1;
                    end else if (dbg_out == PASS_SIG) begin
                        w_state_nxt = ST_PASS;
                        w_pass_nxt  = 1'b1;
                        w_terminal  = 1'b1;
                    end else if (STALL_EN && w_unchanged &&
                                 (r_stall_cnt == CNT_W'(STALL_CYCLES - 1))) begin
                        w_state_nxt = ST_STALL;
                        w_fail_nxt  = 1'b1;
                        w_stall_nxt = 1'b1;
                        w_terminal  = 1'b1;
                    end else if (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1)) begin
                        w_state_nxt   = ST_TIMEOUT;
                        w_timeout_nxt = 1'b1;
                        w_terminal    = 1'b1;
                    end else begin
                        w_terminal = 1'b0;
                    end
                    if (w_terminal) begin
                        w_done_nxt = 1'b1;
                        if (HALT_ON_DONE) begin
                            w_cpu_rst_n_nxt = 1'b0;
                        end else begin
                            w_cpu_rst_n_nxt = r_cpu_rst_n;
                        end
                    end else begin
                        w_done_nxt = r_done;
                    end
                end
                ST_PASS, ST_FAIL, ST_STALL, ST_TIMEOUT: begin
                    // Sticky: everything frozen until restart or rst_n.
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt     = ST_HOLD;
                    w_hold_nxt      = {HOLD_W{1'b0}};
                    w_cpu_rst_n_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= {HOLD_W{1'b0}};
            r_cycle_cnt <= {CNT_W{1'b0}};
            r_stall_cnt <= {CNT_W{1'b0}};
            r_dbg_q     <= {DBG_W{1'b0}};
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_cycle_cnt <= w_cycle_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_dbg_q     <= w_dbg_nxt;
            r_cpu_rst_n <= w_cpu_rst_n_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_timeout   <= w_timeout_nxt;
            r_stall     <= w_stall_nxt;
        end
    end

    assign cpu_rst_n = r_cpu_rst_n;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign timeout   = r_timeout;
    assign stall     = r_stall;
    assign cycle_cnt = r_cycle_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Testbench for cpu_run_monitor: scenario tasks with a scoreboard of expected
// terminal snapshots {state, cpu_rst_n, done, pass, fail, stall, timeout, cycle_cnt}.
`timescale 1ns/1ps
module tb_cpu_run_monitor;

    localparam logic [31:0] PSIG = 32'h600DC0DE;
    localparam logic [31:0] FSIG = 32'hBADC0DE0;

    logic        clk;
    logic        rst_n;
    logic        restart;
    logic [31:0] dbg_out;
    logic        cpu_rst_n;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        stall;
    logic [31:0] cycle_cnt;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;
    logic [40:0] sb_q[$];

    cpu_run_monitor #(
        .DBG_W(32), .CNT_W(32), .RST_CYCLES(10), .MAX_CYCLES(1000),
        .PASS_SIG(PSIG), .FAIL_SIG(FSIG), .STALL_CYCLES(16), .HALT_ON_DONE(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .dbg_out(dbg_out),
        .cpu_rst_n(cpu_rst_n), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .stall(stall), .cycle_cnt(cycle_cnt), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [40:0] snap(input logic [2:0] st, input logic rn, input logic d,
                                         input logic p, input logic f, input logic s,
                                         input logic t, input logic [31:0] c);
        return {st, rn, d, p, f, s, t, c};
    endfunction

    function automatic logic [40:0] obs();
        return {state, cpu_rst_n, done, pass, fail, stall, timeout, cycle_cnt};
    endfunction

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (done === 1'b1);
        end
    endtask

    // Restart pulse then the full 10-cycle hold; returns at the first RUN negedge.
    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [40:0] e;
        rst_n = 1'b0; restart = 1'b0; dbg_out = 32'h0;
        repeat (10) @(negedge clk);
        e = snap(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_checks++;
        if (obs() !== e) begin n_errors++; $display("FAIL reset_state: got %h required %h", obs(), e); end
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                n_checks++;
                if (obs() !== e) begin n_errors++; $display("FAIL hold_9_edges: got %h required %h", obs(), e); end
            end
            if (i == 10) begin
                e = snap(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
                n_checks++;
                if (obs() !== e) begin n_errors++; $display("FAIL run_at_10_edges: got %h required %h", obs(), e); end
            end
        end
    endtask

    task automatic test_pass();
        logic [40:0] e;
        bit ok;
        for (int k = 0; k < 57; k++) begin
            if (k == 30) begin
                n_checks++;
                if (cycle_cnt !== 32'd30) begin n_errors++; $display("FAIL run_count: got %0d required 30", cycle_cnt); end
            end
            dbg_out = 32'h100 + 32'(k);
            @(negedge clk);
        end
        dbg_out = PSIG;
        e = snap(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd58);
        sb_q.push_back(e);
        wait_done(20, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== e) begin n_errors++; $display("FAIL pass_at_57: got %h required %h", obs(), e); end
        dbg_out = FSIG;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs() !== e) begin n_errors++; $display("FAIL pass_frozen: got %h required %h", obs(), e); end
    endtask

    task automatic test_fail_priority();
        logic [40:0] e;
        bit ok;
        do_restart();
        for (int k = 0; k < 5; k++) begin
            dbg_out = 32'h200 + 32'(k);
            @(negedge clk);
        end
        dbg_out = FSIG;
        e = snap(3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd6);
        sb_q.push_back(e);
        @(negedge clk);
        dbg_out = PSIG;
        if (done !== 1'b1) wait_done(20, ok); else ok = 1'b1;
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== e) begin n_errors++; $display("FAIL fail_then_pass: got %h required %h", obs(), e); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs() !== e) begin n_errors++; $display("FAIL fail_sticky: got %h required %h", obs(), e); end
    endtask

    task automatic test_timeout();
        logic [40:0] e;
        bit ok;
        do_restart();
        e = snap(3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1000);
        sb_q.push_back(e);
        ok = 1'b0;
        for (int k = 0; k < 1100 && !ok; k++) begin
            if (k == 999) begin
                n_checks++;
                if (state !== 3'd1 || cpu_rst_n !== 1'b1 || cycle_cnt !== 32'd999) begin
                    n_errors++;
                    $display("FAIL pre_timeout: state=%0d cpu_rst_n=%b cnt=%0d required 1 1 999", state, cpu_rst_n, cycle_cnt);
                end
            end
            dbg_out = (k % 2 == 0) ? 32'hA : 32'hB;
            @(negedge clk);
            ok = (done === 1'b1);
        end
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== e) begin n_errors++; $display("FAIL timeout_1000: got %h required %h", obs(), e); end
    endtask

    task automatic test_stall();
        logic [40:0] e;
        bit ok;
        do_restart();
        dbg_out = 32'h5;
        e = snap(3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd17);
        sb_q.push_back(e);
        wait_done(40, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== e) begin n_errors++; $display("FAIL stall_held: got %h required %h", obs(), e); end
        do_restart();
        for (int k = 0; k < 10; k++) begin
            dbg_out = 32'h5;
            @(negedge clk);
        end
        dbg_out = 32'h6;
        e = snap(3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd27);
        sb_q.push_back(e);
        wait_done(40, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== e) begin n_errors++; $display("FAIL stall_change_at_10: got %h required %h", obs(), e); end
    endtask

    task automatic test_restart();
        logic [40:0] e;
        logic [40:0] hold_e;
        bit ok;
        hold_e = snap(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        do_restart();
        for (int k = 0; k < 300; k++) begin
            dbg_out = 32'h1000 + 32'(k);
            @(negedge clk);
        end
        n_checks++;
        if (cycle_cnt !== 32'd300 || state !== 3'd1) begin
            n_errors++; $display("FAIL run_300: cnt=%0d state=%0d required 300 1", cycle_cnt, state);
        end
        restart = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs() !== hold_e) begin n_errors++; $display("FAIL restart_mid_run: got %h required %h", obs(), hold_e); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs() !== hold_e) begin n_errors++; $display("FAIL restart_held: got %h required %h", obs(), hold_e); end
        restart = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                n_checks++;
                if (obs() !== hold_e) begin n_errors++; $display("FAIL rehold_9: got %h required %h", obs(), hold_e); end
            end
        end
        e = snap(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_checks++;
        if (obs() !== e) begin n_errors++; $display("FAIL rehold_10: got %h required %h", obs(), e); end
        for (int k = 0; k < 3; k++) begin
            dbg_out = 32'h3000 + 32'(k);
            @(negedge clk);
        end
        dbg_out = PSIG;
        sb_q.push_back(snap(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4));
        wait_done(20, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== e) begin n_errors++; $display("FAIL rerun_pass: got %h required %h", obs(), e); end
        // Restart from a terminal state.
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_checks++;
        if (obs() !== hold_e) begin n_errors++; $display("FAIL restart_in_pass: got %h required %h", obs(), hold_e); end
        repeat (10) @(negedge clk);
        dbg_out = PSIG;
        sb_q.push_back(snap(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1));
        wait_done(20, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok || obs() !== e) begin n_errors++; $display("FAIL back_to_back_pass: got %h required %h", obs(), e); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_priority();
        test_timeout();
        test_stall();
        test_restart();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
